z80_bus_arbiter: RTL and testbench

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

---
 rtl/z80_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_z80_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_arbiter.sv
// Bus arbiter that borrows the Z80 memory bus for a DMA requester via BUSRQ/BUSAK
// and steers a synchronous SRAM between the CPU and the DMA port.
module z80_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int HOLDOFF   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        busrq_n,
    input  logic        busak_n,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLDOFF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DMA,
        ST_REL,
        ST_HOLD
    } state_t;

    state_t     state_reg;
    logic [7:0] burst_reg;
    logic [7:0] hold_reg;
    logic       busrq_n_reg;
    logic       dma_gnt_reg;
    logic       rvalid_reg;

    logic       dma_mode;
    logic [7:0] burst_next;

    assign dma_mode   = (state_reg == ST_DMA);
    assign burst_next = burst_reg + 8'd1;

    assign busrq_n    = busrq_n_reg;
    assign dma_gnt    = dma_gnt_reg;
    assign dma_ack    = dma_mode & dma_req;
    assign dma_rvalid = rvalid_reg;
    // SRAM data is already one cycle late, so both return paths are plain wires.
    assign dma_rdata  = mem_rdata;
    assign cpu_din    = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            burst_reg   <= 8'd0;
            hold_reg    <= 8'd0;
            busrq_n_reg <= 1'b1;
            dma_gnt_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
        end else begin
            rvalid_reg <= dma_ack & ~dma_we;
            case (state_reg)
                ST_IDLE: begin
                    if (dma_req) begin
                        state_reg   <= ST_REQ;
                        busrq_n_reg <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Once requested the Z80 handshake is always completed.
                    if (!busak_n) begin
                        state_reg   <= ST_DMA;
                        dma_gnt_reg <= 1'b1;
                        burst_reg   <= 8'd0;
                    end
                end
                ST_DMA: begin
                    if (dma_req) begin
                        burst_reg <= burst_next;
                    end
                    if (!dma_req || (burst_next == BURST_LIMIT)) begin
                        state_reg   <= ST_REL;
                        busrq_n_reg <= 1'b1;
                        dma_gnt_reg <= 1'b0;
                    end
                end
                ST_REL: begin
                    if (busak_n) begin
                        if (HOLD_LOAD == 8'd0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_HOLD;
                            hold_reg  <= HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    hold_reg <= hold_reg - 8'd1;
                    if (hold_reg <= 8'd1) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    busrq_n_reg <= 1'b1;
                    dma_gnt_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_cs    = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
        mem_we    = ~cpu_mreq_n & ~cpu_wr_n;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        if (dma_mode) begin
            mem_cs    = dma_req;
            mem_we    = dma_req & dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: two instances (16/4 and 1/0), Z80 BUSAK models with a
// three-cycle acknowledge delay and a behavioural synchronous SRAM.
module tb_z80_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mreq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_dout = 8'h0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic [7:0]  dma_wdata = 8'h0;
    logic [7:0]  mem_rdata;

    logic        busrq_n, busak_n, dma_gnt, dma_ack, dma_rvalid, mem_cs, mem_we;
    logic [7:0]  cpu_din, dma_rdata, mem_wdata;
    logic [15:0] mem_addr;

    logic        busrq1_n, busak1_n, dma_gnt1, dma_ack1, dma_rvalid1, mem_cs1, mem_we1;
    logic [7:0]  cpu_din1, dma_rdata1, mem_wdata1;
    logic [15:0] mem_addr1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    z80_bus_arbiter #(.MAX_BURST(16), .HOLDOFF(4)) u0 (
        .clk(clk), .reset(reset), .busrq_n(busrq_n), .busak_n(busak_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    z80_bus_arbiter #(.MAX_BURST(1), .HOLDOFF(0)) u1 (
        .clk(clk), .reset(reset), .busrq_n(busrq1_n), .busak_n(busak1_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt1), .dma_ack(dma_ack1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
        .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata)
    );

    // Z80 acknowledges (and releases) the bus three cycles after BUSRQ changes.
    logic [2:0] ak0_sr, ak1_sr;
    always @(posedge clk) begin
        if (reset) begin
            ak0_sr <= 3'b111;
            ak1_sr <= 3'b111;
        end else begin
            ak0_sr <= {ak0_sr[1:0], busrq_n};
            ak1_sr <= {ak1_sr[1:0], busrq1_n};
        end
    end
    assign busak_n  = ak0_sr[2];
    assign busak1_n = ak1_sr[2];

    // Synchronous SRAM on u0's memory port, with a bench-side preload path.
    logic [7:0]  sram [0:65535];
    logic [7:0]  sram_q = 8'h0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0;
    logic [7:0]  pl_data = 8'h0;
    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else sram_q <= sram[mem_addr];
        end
    end
    assign mem_rdata = sram_q;

    logic [7:0] shadow [0:15];

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        dma_req = 1'b0; dma_we = 1'b0;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; dma_req = 1'b1; dma_we = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (busrq_n !== 1'b1) begin fails++; $display("FAIL reset_busrq got %b want 1", busrq_n); end
        tests++; if (dma_gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt got %b want 0", dma_gnt); end
        tests++; if (dma_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", dma_ack); end
        tests++; if (dma_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", dma_rvalid); end
        tests++; if (mem_cs !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem got cs=%b we=%b want 0 0", mem_cs, mem_we); end
        tests++; if (busrq1_n !== 1'b1 || dma_gnt1 !== 1'b0 || dma_ack1 !== 1'b0 || dma_rvalid1 !== 1'b0)
            begin fails++; $display("FAIL reset_u1 got rq=%b gnt=%b ack=%b rv=%b want 1 0 0 0", busrq1_n, dma_gnt1, dma_ack1, dma_rvalid1); end
        tests++; if (mem_cs1 !== 1'b0 || mem_we1 !== 1'b0) begin fails++; $display("FAIL reset_u1_mem got cs=%b we=%b want 0 0", mem_cs1, mem_we1); end
        dma_req = 1'b0;
        reset = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_burst_write();
        int acks = 0, gap = 0;
        bit started = 0, ended = 0, hi = 0, rereq = 0;
        logic [15:0] a; logic [7:0] d;
        settle();
        for (int c = 0; c < 200 && !ended; c++) begin
            @(negedge clk);
            a = 16'h4000 | 16'($urandom_range(0, 255)); d = 8'($urandom);
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = a; dma_wdata = d;
            #1;
            if (busrq_n == 1'b0) started = 1;
            if (dma_ack) begin
                acks++;
                tests++;
                if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
                    fails++; $display("FAIL bw_mem got cs=%b we=%b a=%h d=%h want 1 1 %h %h", mem_cs, mem_we, mem_addr, mem_wdata, a, d);
                end
            end
            if (started && busrq_n == 1'b1) ended = 1;
        end
        tests++; if (acks != 16) begin fails++; $display("FAIL bw_acks got %0d want 16", acks); end
        for (int c = 0; c < 60 && !rereq; c++) begin
            @(negedge clk); #1;
            if (busak_n == 1'b1) hi = 1;
            if (hi && busrq_n == 1'b0) rereq = 1;
            else if (hi) gap++;
        end
        tests++; if (!rereq || gap != 6) begin fails++; $display("FAIL bw_holdoff got gap=%0d rereq=%0d want 6 1", gap, rereq); end
        $display("[TB] test_burst_write acks=%0d gap=%0d", acks, gap);
    endtask

    task automatic test_burst_read();
        int idx = 0, run = 0, maxrun = 0, rvs = 0;
        bit prev_ack = 0; logic [7:0] prev_exp = 8'h0;
        settle();
        for (int i = 0; i < 4; i++) preload(16'h1000 + 16'(i), 8'(8'hA0 + i));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            dma_req = (idx < 4); dma_we = 1'b0; dma_addr = 16'h1000 + 16'(idx);
            #1;
            tests++;
            if (prev_ack) begin
                if (dma_rvalid !== 1'b1 || dma_rdata !== prev_exp) begin
                    fails++; $display("FAIL br_data got rv=%b d=%h want 1 %h", dma_rvalid, dma_rdata, prev_exp);
                end
            end else if (dma_rvalid !== 1'b0) begin
                fails++; $display("FAIL br_spurious got rv=%b want 0", dma_rvalid);
            end
            if (dma_rvalid) begin run++; rvs++; end else run = 0;
            if (run > maxrun) maxrun = run;
            prev_ack = dma_ack;
            prev_exp = 8'(8'hA0 + idx);
            if (dma_ack) idx++;
        end
        tests++; if (rvs != 4 || maxrun != 4) begin fails++; $display("FAIL br_count got rv=%0d run=%0d want 4 4", rvs, maxrun); end
        $display("[TB] test_burst_read reads=%0d", rvs);
    endtask

    task automatic test_cpu_passthrough();
        logic [7:0] v, w;
        bit got = 0;
        settle();
        v = 8'($urandom); w = 8'($urandom);
        preload(16'h2000, v);
        @(negedge clk);
        cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_rd_n = 1'b1; cpu_addr = 16'h2001; cpu_dout = w;
        #1;
        tests++; if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h2001 || mem_wdata !== w) begin
            fails++; $display("FAIL cpu_write got cs=%b we=%b a=%h d=%h want 1 1 2001 %h", mem_cs, mem_we, mem_addr, mem_wdata, w);
        end
        @(negedge clk);
        cpu_wr_n = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h2000; dma_req = 1'b1; dma_we = 1'b1;
        for (int n = 0; n < 30 && !got; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (busak_n == 1'b0) got = 1;
            else begin
                tests++;
                if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h2000 || dma_gnt !== 1'b0) begin
                    fails++; $display("FAIL cpu_read got cs=%b we=%b a=%h gnt=%b want 1 0 2000 0", mem_cs, mem_we, mem_addr, dma_gnt);
                end
                if (n > 0) begin
                    tests++; if (cpu_din !== v) begin fails++; $display("FAIL cpu_din got %h want %h", cpu_din, v); end
                end
            end
        end
        tests++; if (!got) begin fails++; $display("FAIL cpu_busak got timeout want busak_n=0"); end
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        $display("[TB] test_cpu_passthrough v=%h", v);
    endtask

    task automatic test_drop_early();
        int gnts = 0, acks = 0, gap = 0;
        bit low = 0, hi = 0, rereq = 0;
        settle();
        @(negedge clk); dma_req = 1'b1; dma_we = 1'b0;
        @(negedge clk); dma_req = 1'b0;
        for (int c = 0; c < 60 && !rereq; c++) begin
            @(negedge clk);
            if (hi) dma_req = 1'b1;
            #1;
            if (dma_gnt) gnts++;
            if (dma_ack) acks++;
            if (busak_n == 1'b0) low = 1;
            if (low && busak_n == 1'b1) hi = 1;
            if (hi && busrq_n == 1'b0) rereq = 1;
            else if (hi) gap++;
        end
        tests++; if (gnts != 1) begin fails++; $display("FAIL de_gnt got %0d want 1", gnts); end
        tests++; if (acks != 0) begin fails++; $display("FAIL de_acks got %0d want 0", acks); end
        tests++; if (!rereq || gap != 6) begin fails++; $display("FAIL de_hold got gap=%0d rereq=%0d want 6 1", gap, rereq); end
        $display("[TB] test_drop_early gnt=%0d gap=%0d", gnts, gap);
    endtask

    task automatic test_reset_mid_burst();
        int acks = 0;
        bit started = 0, ended = 0;
        settle();
        for (int c = 0; c < 40 && acks < 5; c++) begin
            @(negedge clk);
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h1000 + 16'(acks);
            #1;
            if (dma_ack) acks++;
        end
        reset = 1'b1;
        tests++; if (acks != 5) begin fails++; $display("FAIL rm_reach got %0d want 5", acks); end
        @(negedge clk); #1;
        tests++; if (busrq_n !== 1'b1 || dma_gnt !== 1'b0) begin fails++; $display("FAIL rm_bus got rq=%b gnt=%b want 1 0", busrq_n, dma_gnt); end
        tests++; if (mem_cs !== 1'b0 || dma_rvalid !== 1'b0) begin fails++; $display("FAIL rm_mem got cs=%b rv=%b want 0 0", mem_cs, dma_rvalid); end
        reset = 1'b0; dma_req = 1'b0;
        repeat (6) @(negedge clk);
        acks = 0;
        for (int c = 0; c < 200 && !ended; c++) begin
            @(negedge clk);
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4100; dma_wdata = 8'($urandom);
            #1;
            if (busrq_n == 1'b0) started = 1;
            if (dma_ack) acks++;
            if (started && busrq_n == 1'b1) ended = 1;
        end
        tests++; if (acks != 16) begin fails++; $display("FAIL rm_fresh got %0d want 16", acks); end
        $display("[TB] test_reset_mid_burst fresh=%0d", acks);
    endtask

    task automatic test_max1();
        int tenures = 0, t_acks = 0, t_gnt = 0, gap = 0;
        bit in_ten = 0, had = 0;
        settle();
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'(c); dma_wdata = 8'(c);
            #1;
            if (busrq1_n == 1'b0 && !in_ten) begin
                if (had) begin
                    tests++; if (gap != 2) begin fails++; $display("FAIL m1_gap got %0d want 2", gap); end
                end
                in_ten = 1; t_acks = 0; t_gnt = 0; gap = 0;
            end
            if (dma_ack1) begin
                t_acks++;
                tests++; if (mem_we1 !== 1'b1 || mem_addr1 !== 16'(c) || mem_wdata1 !== 8'(c)) begin
                    fails++; $display("FAIL m1_mem got we=%b a=%h d=%h want 1 %h %h", mem_we1, mem_addr1, mem_wdata1, 16'(c), 8'(c));
                end
            end
            if (dma_gnt1) t_gnt++;
            if (in_ten && busrq1_n == 1'b1) begin
                tests++; if (t_acks != 1 || t_gnt != 1) begin fails++; $display("FAIL m1_tenure got acks=%0d gnt=%0d want 1 1", t_acks, t_gnt); end
                tenures++; in_ten = 0; had = 1;
            end else if (had && !in_ten && busak1_n == 1'b1) gap++;
        end
        tests++; if (tenures < 5) begin fails++; $display("FAIL m1_count got %0d want >=5", tenures); end
        $display("[TB] test_max1 tenures=%0d", tenures);
    endtask

    task automatic test_random();
        bit exp_rv = 0; logic [7:0] exp_rd = 8'h0;
        int t_acks = 0, reads = 0;
        bit in_ten = 0;
        logic [3:0] off;
        settle();
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 8'($urandom);
            preload(16'h3000 + 16'(i), shadow[i]);
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            off = 4'($urandom);
            dma_req = ($urandom_range(0, 3) != 0); dma_we = 1'($urandom);
            dma_addr = 16'h3000 + 16'(off); dma_wdata = 8'($urandom);
            #1;
            tests++;
            if (dma_rvalid !== exp_rv || (exp_rv && dma_rdata !== exp_rd)) begin
                fails++; $display("FAIL rnd_rv c=%0d got rv=%b d=%h want %b %h", c, dma_rvalid, dma_rdata, exp_rv, exp_rd);
            end
            tests++;
            if (dma_ack !== (dma_gnt & dma_req)) begin
                fails++; $display("FAIL rnd_ack c=%0d got %b want %b", c, dma_ack, dma_gnt & dma_req);
            end
            if (dma_ack) begin
                tests++;
                if (mem_cs !== 1'b1 || mem_we !== dma_we || mem_addr !== dma_addr || (dma_we && mem_wdata !== dma_wdata)) begin
                    fails++; $display("FAIL rnd_mem c=%0d got cs=%b we=%b a=%h want 1 %b %h", c, mem_cs, mem_we, mem_addr, dma_we, dma_addr);
                end
            end else if (!dma_gnt) begin
                tests++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL rnd_idle c=%0d got cs=%b want 0", c, mem_cs); end
            end
            if (busrq_n == 1'b0 && !in_ten) begin in_ten = 1; t_acks = 0; end
            if (dma_ack) t_acks++;
            if (in_ten && busrq_n == 1'b1) begin
                tests++; if (t_acks > 16) begin fails++; $display("FAIL rnd_burst got %0d want <=16", t_acks); end
                in_ten = 0;
            end
            exp_rv = dma_ack && !dma_we;
            exp_rd = shadow[off];
            if (exp_rv) reads++;
            if (dma_ack && dma_we) shadow[off] = dma_wdata;
        end
        $display("[TB] test_random reads=%0d", reads);
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_burst_read();
        test_cpu_passthrough();
        test_drop_early();
        test_reset_mid_burst();
        test_max1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
